// File: rtl/mux_scan_sampler_pkg.sv
// Shared types and constants for the mux scan sampler: state encoding,
// channel count and select width, plus the sample-word assembly helper.
package mux_scan_sampler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    function automatic logic [NUM_CH-1:0] assemble_word(
        input logic              last_bit,
        input logic [NUM_CH-2:0] low_bits
    );
        return {last_bit, low_bits};
    endfunction

endpackage

// File: rtl/mux_scan_sampler_settle_counter.sv
// Settle-window counter: counts clocks while enabled, reloads to zero on clear,
// and flags the terminal count at SETTLE_CYCLES-1.
module mux_scan_sampler_settle_counter #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    // Clear wins over enable so a capture edge restarts the window at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == TERMINAL);

endmodule

// File: rtl/mux_scan_sampler.sv
// Steps the 4:1 mux select through every channel, captures one bit per channel
// after a settle window and publishes the reconstructed input word.
module mux_scan_sampler
    import mux_scan_sampler_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    output logic [SEL_W-1:0]  sel,
    input  logic              mux_out,
    output logic [NUM_CH-1:0] sample,
    output logic              sample_valid,
    output logic              changed,
    output logic              busy
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

    state_t            state_r;
    logic [SEL_W-1:0]  sel_r;
    logic [NUM_CH-2:0] shadow_r;
    logic [NUM_CH-1:0] sample_r;
    logic              sample_valid_r;
    logic              changed_r;
    logic              busy_r;
    logic              tc_s;
    logic              clear_s;
    logic              enable_s;
    logic [NUM_CH-1:0] word_s;

    // Counter only runs in SCAN and reloads after every capture.
    always_comb begin
        clear_s  = 1'b1;
        enable_s = 1'b0;
        if (state_r == SCAN) begin
            clear_s  = tc_s;
            enable_s = 1'b1;
        end else begin
            clear_s  = 1'b1;
            enable_s = 1'b0;
        end
    end

    assign word_s = assemble_word(mux_out, shadow_r);

    mux_scan_sampler_settle_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear_s),
        .enable (enable_s),
        .tc     (tc_s)
    );

    // Scan FSM with registered select, shadow capture and word publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            sel_r          <= {SEL_W{1'b0}};
            shadow_r       <= {(NUM_CH-1){1'b0}};
            sample_r       <= {NUM_CH{1'b0}};
            sample_valid_r <= 1'b0;
            changed_r      <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            sample_valid_r <= 1'b0;
            changed_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    sel_r <= {SEL_W{1'b0}};
                    if (start) begin
                        state_r <= SCAN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (tc_s && (sel_r == LAST_SEL)) begin
                        sample_r       <= word_s;
                        sample_valid_r <= 1'b1;
                        changed_r      <= (word_s != sample_r);
                        sel_r          <= {SEL_W{1'b0}};
                        if (continuous) begin
                            state_r <= SCAN;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else if (tc_s) begin
                        case (sel_r)
                            2'd0:    shadow_r[0] <= mux_out;
                            2'd1:    shadow_r[1] <= mux_out;
                            2'd2:    shadow_r[2] <= mux_out;
                            default: shadow_r    <= shadow_r;
                        endcase
                        sel_r <= sel_r + SEL_W'(1);
                    end else begin
                        sel_r <= sel_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    sel_r   <= {SEL_W{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign sel          = sel_r;
    assign sample       = sample_r;
    assign sample_valid = sample_valid_r;
    assign changed      = changed_r;
    assign busy         = busy_r;

endmodule
